// File: rtl/cnn_layer_sequencer.sv
// CNN layer sequencer: steps CONV1 -> CONV2 -> FC per frame, pulses stage begins.
// Optional watchdog with ERR state compiled in by defining SEQ_TIMEOUT_EN.
module cnn_layer_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FRAME_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               clear_err,
    input  logic               done_conv1,
    input  logic               done_conv2,
    input  logic               done_fc,
    output logic               begin_conv1,
    output logic               begin_conv2,
    output logic               begin_fc,
    output logic               busy,
    output logic               result_valid,
    output logic               error,
    output logic [2:0]         stage,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV1 = 3'd1,
        S_CONV2 = 3'd2,
        S_FC    = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_nxt;
    logic   w_first;
    logic   w_tmo;
    logic   w_clr;
    logic   w_busy_nxt;

    // A begin pulse marks the first stage cycle, where any done is stale.
    assign w_first = begin_conv1 | begin_conv2 | begin_fc;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;

    assign w_tmo = (r_wdog == WD_LAST);
    assign w_clr = clear_err;
`else
    logic [1:0] w_unused_cfg;

    assign w_unused_cfg = {clear_err, 1'(TIMEOUT_CYCLES == 0)};
    assign w_tmo        = 1'b0;
    assign w_clr        = 1'b0;
    assign error        = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start)
                    w_nxt = S_CONV1;
            end
            S_CONV1: begin
                if (abort)
                    w_nxt = S_IDLE;
                else if (!w_first && done_conv1)
                    w_nxt = S_CONV2;
                else if (w_tmo)
                    w_nxt = S_ERR;
            end
            S_CONV2: begin
                if (abort)
                    w_nxt = S_IDLE;
                else if (!w_first && done_conv2)
                    w_nxt = S_FC;
                else if (w_tmo)
                    w_nxt = S_ERR;
            end
            S_FC: begin
                if (abort)
                    w_nxt = S_IDLE;
                else if (!w_first && done_fc)
                    w_nxt = S_DONE;
                else if (w_tmo)
                    w_nxt = S_ERR;
            end
            S_DONE: begin
                w_nxt = start ? S_CONV1 : S_IDLE;
            end
            S_ERR: begin
                if (w_clr)
                    w_nxt = S_IDLE;
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_nxt == S_CONV1) || (w_nxt == S_CONV2) ||
                        (w_nxt == S_FC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            stage        <= 3'd0;
            begin_conv1  <= 1'b0;
            begin_conv2  <= 1'b0;
            begin_fc     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            frame_cnt    <= '0;
`ifdef SEQ_TIMEOUT_EN
            error        <= 1'b0;
            r_wdog       <= 16'd0;
`endif
        end else begin
            r_state      <= w_nxt;
            stage        <= w_nxt;
            begin_conv1  <= (w_nxt == S_CONV1) && (r_state != S_CONV1);
            begin_conv2  <= (w_nxt == S_CONV2) && (r_state != S_CONV2);
            begin_fc     <= (w_nxt == S_FC) && (r_state != S_FC);
            busy         <= w_busy_nxt;
            result_valid <= (w_nxt == S_DONE);
            if (w_nxt == S_DONE)
                frame_cnt <= frame_cnt + FRAME_W'(1);
`ifdef SEQ_TIMEOUT_EN
            error <= (w_nxt == S_ERR);
            // No state re-enters itself, so a change of state is a stage entry.
            if (w_nxt != r_state)
                r_wdog <= 16'd0;
            else if (w_busy_nxt)
                r_wdog <= r_wdog + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: frame-level model plus directed scenarios.
// Timeout scenarios run when SEQ_TIMEOUT_EN is defined.
module tb_cnn_layer_sequencer;

    localparam int TMO = 8;
    localparam int FW  = 2;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic clear_err = 1'b0;
    logic [2:0] md = 3'b000;
    logic [2:0] ad = 3'b000;
    logic [2:0] pb = 3'b000;
    logic aen = 1'b0;
    wire [2:0] w_done = md | (ad & {3{aen}});

    logic b1, b2, bf, busy, rv, err;
    logic [2:0] stg;
    logic [FW-1:0] fcnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    cnn_layer_sequencer #(.TIMEOUT_CYCLES(TMO), .FRAME_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .clear_err(clear_err),
        .done_conv1(w_done[0]), .done_conv2(w_done[1]), .done_fc(w_done[2]),
        .begin_conv1(b1), .begin_conv2(b2), .begin_fc(bf),
        .busy(busy), .result_valid(rv), .error(err),
        .stage(stg), .frame_cnt(fcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string n, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc, act, exp);
        end
    endtask

    // Engine responder: answers each begin with done one cycle later.
    always @(negedge clk) begin
        ad = pb;
        pb = {bf, b2, b1};
    end

    // Frame-level model: 0 idle, 1..3 stages, 4 done, 5 error.
    int m_st = 0;
    int m_age = 0;
    bit m_ent = 1'b0;
    logic [FW-1:0] m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin : mdl
        int nx;
        if (!rst_n) begin
            m_st = 0; m_age = 0; m_ent = 1'b0; m_cnt = '0;
        end else begin
            nx = m_st;
            if (m_st >= 1 && m_st <= 3) begin
                if (abort) nx = 0;
                else if (m_age > 0 && w_done[m_st-1]) nx = m_st + 1;
                else if (TMO_EN && m_age == TMO - 1) nx = 5;
            end else if (m_st == 0 || m_st == 4) begin
                nx = start ? 1 : 0;
            end else if (clear_err) begin
                nx = 0;
            end
            m_ent = (nx != m_st);
            m_age = m_ent ? 0 : m_age + 1;
            if (nx == 4) m_cnt++;
            m_st = nx;
        end
    end

    always @(negedge clk) begin
        chk("stage", int'(stg), m_st);
        chk("busy", int'(busy), int'(m_st >= 1 && m_st <= 3));
        chk("begin_conv1", int'(b1), int'(m_ent && m_st == 1));
        chk("begin_conv2", int'(b2), int'(m_ent && m_st == 2));
        chk("begin_fc", int'(bf), int'(m_ent && m_st == 3));
        chk("result_valid", int'(rv), int'(m_st == 4));
        chk("error", int'(err), int'(m_st == 5));
        chk("frame_cnt", int'(fcnt), int'(m_cnt));
    end

    task automatic wait_stage(int s, int lim);
        int k = 0;
        while (int'(stg) != s && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_stage", int'(stg), s);
    endtask

    initial begin
        int s, t1, t2, t3, tr, c_rv, c0, nrv, last_rv;
        int seq [5];
        int exp_seq [5];
        exp_seq = '{1, 2, 3, 0, 1};
        repeat (3) @(negedge clk);
        chk("rst_stage", int'(stg), 0);
        chk("rst_cnt", int'(fcnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame, engines answer after one cycle.
        aen = 1'b1; start = 1'b1; s = cyc;
        t1 = -1; t2 = -1; t3 = -1; tr = -1; c_rv = -1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (b1) t1 = cyc - s;
            if (b2) t2 = cyc - s;
            if (bf) t3 = cyc - s;
            if (rv) begin tr = cyc - s; c_rv = int'(fcnt); end
            @(negedge clk);
        end
        chk("lat_begin_conv1", t1, 1);
        chk("lat_begin_conv2", t2, 3);
        chk("lat_begin_fc", t3, 5);
        chk("lat_result_valid", tr, 7);
        chk("frame_cnt_after", c_rv, 1);
        aen = 1'b0;

`ifndef SEQ_TIMEOUT_EN
        // Stale done through begin, long wait, then abort racing done_conv2.
        start = 1'b1; md[0] = 1'b1; s = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("b1_stale", int'(b1), 1);
        @(negedge clk);
        md[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            md[2] = (k == 5);
            @(negedge clk);
        end
        md[2] = 1'b0;
        chk("hold_conv1", int'(stg), 1);
        md[0] = 1'b1;
        @(negedge clk);
        md[0] = 1'b0;
        chk("b2_after_pulse", int'(b2), 1);
        chk("b2_cycle", cyc - s, 23);
        @(negedge clk);
        abort = 1'b1; md[1] = 1'b1; c0 = int'(fcnt);
        @(negedge clk);
        abort = 1'b0; md[1] = 1'b0;
        chk("abort_stage", int'(stg), 0);
        chk("abort_no_bfc", int'(bf), 0);
        chk("abort_no_rv", int'(rv), 0);
        chk("abort_cnt", int'(fcnt), c0);
`endif

        // Back-to-back frames with start held, counter wraps.
        #2 rst_n = 1'b0;
        #1 chk("rst2_stage", int'(stg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        aen = 1'b1; start = 1'b1; nrv = 0; last_rv = -10;
        for (int k = 0; k < 60 && nrv < 5; k++) begin
            @(negedge clk);
            if (b1 && nrv > 0) chk("b2b_gap", cyc - last_rv, 1);
            if (rv) begin
                seq[nrv] = int'(fcnt);
                last_rv = cyc;
                nrv++;
                if (nrv == 5) start = 1'b0;
            end
        end
        chk("b2b_frames", nrv, 5);
        for (int i = 0; i < 5; i++) chk("wrap_seq", seq[i], exp_seq[i]);
        @(negedge clk);
        chk("b2b_idle", int'(stg), 0);

        // Asynchronous reset while in FC.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_stage(3, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_stage", int'(stg), 0);
        chk("ar_bfc", int'(bf), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_rv", int'(rv), 0);
        chk("ar_cnt", int'(fcnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        aen = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_idle", int'(stg), 0);
        aen = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ar_restart_b1", int'(b1), 1);
        tr = 0;
        for (int k = 0; k < 12 && tr == 0; k++) begin
            @(negedge clk);
            if (rv) tr = 1;
        end
        chk("ar_restart_rv", tr, 1);
        chk("ar_restart_cnt", int'(fcnt), 1);
        aen = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
        // Watchdog expiry in FC, clear, then done on the last allowed cycle.
        for (int r = 0; r < 2; r++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            md[0] = 1'b1;
            @(negedge clk);
            md[0] = 1'b0;
            @(negedge clk);
            md[1] = 1'b1;
            @(negedge clk);
            md[1] = 1'b0;
            chk("to_fc_entry", int'(stg), 3);
            if (r == 0) begin
                repeat (8) @(negedge clk);
                chk("to_err_stage", int'(stg), 5);
                chk("to_err_flag", int'(err), 1);
                chk("to_err_busy", int'(busy), 0);
                clear_err = 1'b1;
                @(negedge clk);
                clear_err = 1'b0;
                chk("to_clear", int'(stg), 0);
            end else begin
                repeat (7) @(negedge clk);
                md[2] = 1'b1;
                @(negedge clk);
                md[2] = 1'b0;
                chk("to_done_wins", int'(stg), 4);
                chk("to_done_rv", int'(rv), 1);
            end
            @(negedge clk);
        end
`else
        // Without the watchdog a stage waits forever and clear_err is inert.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            clear_err = (k == 10);
            @(negedge clk);
        end
        clear_err = 1'b0;
        chk("nowd_hold", int'(stg), 1);
        chk("nowd_err", int'(err), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("nowd_abort", int'(stg), 0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: per-stage watchdog limit in clk cycles; legal range 2..65535.
REQ-002 SHALL have parameter FRAME_W, default 8: width of frame_cnt.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1: request one inference frame.
REQ-006 SHALL have port abort  input  1: synchronous abandon of the current frame.
REQ-007 SHALL have port clear_err  input  1: leave ERR state.
REQ-008 SHALL have ports begin_conv1, begin_conv2, begin_fc  output  1 each: one-cycle stage start pulses.
REQ-009 SHALL have ports done_conv1, done_conv2, done_fc  input  1 each: stage completion from the engines.
REQ-010 SHALL have port busy  output  1: high in CONV1, CONV2 and FC.
REQ-011 SHALL have port result_valid  output  1: one-cycle pulse; out_fmap/fc results are final.
REQ-012 SHALL have port error  output  1: high while in ERR.
REQ-013 SHALL have port stage  output  3: state code IDLE=0, CONV1=1, CONV2=2, FC=3, DONE=4, ERR=5.
REQ-014 SHALL have port frame_cnt  output  FRAME_W: count of completed frames.

Function
REQ-015 SHALL implement FSM IDLE->CONV1->CONV2->FC->DONE->IDLE; all outputs registered.
REQ-016 IDLE with start=1 SHALL enter CONV1 next cycle; begin_conv1=1 in exactly that first CONV1 cycle.
REQ-017 Each begin_* SHALL be high only in the first cycle of its stage; done_* SHALL be ignored in that cycle (stale done from a prior run).
REQ-018 In CONV1/CONV2/FC, a sampled done of the matching stage SHALL move to the next state, whose begin_* pulses in its first cycle; done_* of non-matching stages SHALL be ignored.
REQ-019 DONE SHALL last exactly one cycle with result_valid=1 and frame_cnt incremented by 1, wrapping from 2^FRAME_W-1 to 0.
REQ-020 start=1 in DONE SHALL go directly to CONV1 (back-to-back frame); otherwise DONE goes to IDLE.
REQ-021 start while busy or in ERR SHALL be ignored and not queued.
REQ-022 abort=1 in CONV1/CONV2/FC SHALL return to IDLE next cycle with no result_valid and no frame_cnt change; abort has priority over done and start; abort in IDLE/DONE/ERR has no effect.
REQ-023 Minimum start-to-result_valid latency SHALL be 7 cycles (each engine done arriving one cycle after its begin).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, all begin_* 0, busy 0, result_valid 0, error 0, stage 0, frame_cnt 0, watchdog counter 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no result_valid; first begin_conv1 requires a fresh start after rst_n rises.

Configuration
REQ-026 Macro SEQ_TIMEOUT_EN, when defined, SHALL compile in a watchdog counter cleared on entry to each stage and incremented each cycle in CONV1/CONV2/FC.
REQ-027 With SEQ_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES-1 without a matching done SHALL enter ERR next cycle; done in that same cycle SHALL win; abort in that cycle SHALL win over both.
REQ-028 With SEQ_TIMEOUT_EN, ERR SHALL hold (error=1, busy=0) until clear_err=1, then go to IDLE next cycle; frame_cnt unchanged.
REQ-029 Without SEQ_TIMEOUT_EN, no counter SHALL exist, error SHALL be constant 0, clear_err ignored, ERR unreachable, stages wait indefinitely.

Verification
REQ-030 start pulse, each done 1 cycle after its begin -> begin_conv1/conv2/fc at cycles 1/3/5, result_valid at cycle 7, frame_cnt 0->1.
REQ-031 done_conv1 held high through the begin_conv1 cycle, then low 20 cycles, then pulse -> no advance until the pulse; begin_conv2 one cycle after it.
REQ-032 abort in CONV2 concurrent with done_conv2 -> stage=0 next cycle, no begin_fc, no result_valid, frame_cnt unchanged.
REQ-033 start held high continuously, FRAME_W=2, 5 frames -> begin_conv1 in the cycle after each DONE, frame_cnt sequence 1,2,3,0,1.
REQ-034 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, done_fc never -> ERR 8 cycles after FC entry, error=1; clear_err -> stage=0 next cycle; done_fc on cycle 8 instead -> DONE, not ERR.
REQ-035 rst_n low for 1 cycle in FC -> all outputs 0 asynchronously; no result_valid; next start restarts at CONV1.
